// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQ,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    // Host-driven bits after the start bit: 8 data, parity, stop.
    localparam int FRAME_LEN = 10;
    localparam int IDX_W     = 4;

    function automatic int us_to_cycles(input int clk_hz, input int us);
        return clk_hz / 1_000_000 * us;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for an asynchronous PS/2 pin with a falling-edge pulse.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    // Idle bus level is high; resetting to 1 avoids a false edge after reset.
    logic [2:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 3'b111;
        end else begin
            sync_reg <= {sync_reg[1:0], din};
        end
    end

    assign level = sync_reg[1];
    assign fall  = sync_reg[2] & ~sync_reg[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shifted on device clock falls, ACK check.
// Optional per-transfer watchdog is compiled in when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);

    localparam int INHIBIT_CYC = us_to_cycles(CLK_HZ, INHIBIT_US);
    localparam int TIMEOUT_CYC = us_to_cycles(CLK_HZ, TIMEOUT_US);
    localparam int CNT_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FRAME_LEN - 1);

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [IDX_W-1:0]       idx_reg, idx_next;
    logic [FRAME_LEN-1:0]   frame_reg;
    logic                   clk_oe_reg, clk_oe_next;
    logic                   dat_oe_reg, dat_oe_next;
    logic                   done_reg, done_next;
    logic                   err_reg, err_next;
    logic [1:0]             err_code_reg, err_code_next;

    logic clk_level, clk_fall, dat_level, dat_fall_unused;
    logic timeout_hit;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_dat_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (ps2_dat_in),
        .level (dat_level),
        .fall  (dat_fall_unused)
    );

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic wd_active;
    assign wd_active   = (state_reg != ST_IDLE) && (state_reg != ST_INHIBIT);
    assign timeout_hit = wd_active && (cnt_reg == TIMEOUT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            idx_reg      <= '0;
            frame_reg    <= '0;
            clk_oe_reg   <= 1'b0;
            dat_oe_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            idx_reg      <= idx_next;
            clk_oe_reg   <= clk_oe_next;
            dat_oe_reg   <= dat_oe_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            err_code_reg <= err_code_next;
            // Frame is {stop, odd parity, data}; bit 0 goes out first.
            if (state_reg == ST_IDLE && tx_valid) begin
                frame_reg <= {1'b1, ~^tx_data, tx_data};
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (tx_valid) begin
                    state_next = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_reg == INHIBIT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_REQ;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_REQ, ST_SHIFT: begin
                if (clk_fall) begin
                    idx_next   = idx_reg + IDX_W'(1);
                    state_next = (idx_reg == IDX_LAST) ? ST_ACK : ST_SHIFT;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    state_next = dat_level ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_level && dat_level) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
`ifdef PS2_TX_TIMEOUT_EN
        if (wd_active) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
`endif
        if (timeout_hit) begin
            state_next = ST_IDLE;
        end
    end

    // Outputs are registered from the upcoming state so pins move with the state change.
    always_comb begin
        clk_oe_next   = 1'b0;
        dat_oe_next   = dat_oe_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;
        err_code_next = err_code_reg;
        case (state_next)
            ST_INHIBIT: begin
                clk_oe_next = 1'b1;
                dat_oe_next = (cnt_next == INHIBIT_LAST);
            end
            ST_REQ:           dat_oe_next = 1'b1;
            ST_SHIFT, ST_ACK: begin
                if (clk_fall) begin
                    dat_oe_next = ~frame_reg[idx_reg];
                end
            end
            default:          dat_oe_next = 1'b0;
        endcase
        if (timeout_hit) begin
            err_next      = 1'b1;
            err_code_next = ERR_TIMEOUT;
        end else if (state_reg == ST_ACK && state_next == ST_IDLE) begin
            err_next      = 1'b1;
            err_code_next = ERR_NACK;
        end else if (state_reg == ST_WAIT_IDLE && state_next == ST_IDLE) begin
            done_next = 1'b1;
        end
    end

    assign tx_ready   = (state_reg == ST_IDLE);
    assign ps2_clk_oe = clk_oe_reg;
    assign ps2_dat_oe = dat_oe_reg;
    assign done       = done_reg;
    assign err        = err_reg;
    assign err_code   = err_code_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain pin model and a simple PS/2 device model.
module tb_ps2_host_tx;

    localparam int TB_TIMEOUT_US = 50;
    localparam int TIMEOUT_CYC   = 2500;
    localparam int INHIBIT_CYC   = 6000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_dat_oe, done, err;
    logic [1:0] err_code;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_in, ps2_dat_in;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .CLK_HZ     (50_000_000),
        .INHIBIT_US (120),
        .TIMEOUT_US (TB_TIMEOUT_US)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    int checks = 0;
    int failures = 0;

    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, accept_cnt = 0;
    int clk_oe_run = 0, last_run = 0, release_cyc = 0, done_cyc = 0, err_cyc = 0, accept_cyc = 0;
    logic [1:0] err_code_seen = 2'b00;
    logic [1:0] err_oe_seen = 2'b00;
    logic prev_done = 1'b0, prev_ready = 1'b1, ready_after_done = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ps2_clk_oe === 1'b1) begin
            clk_oe_run <= clk_oe_run + 1;
        end else begin
            clk_oe_run <= 0;
            if (clk_oe_run != 0) begin
                last_run    <= clk_oe_run;
                release_cyc <= cyc;
            end
        end
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (err === 1'b1) begin
            err_cnt       <= err_cnt + 1;
            err_cyc       <= cyc;
            err_code_seen <= err_code;
            err_oe_seen   <= {ps2_clk_oe, ps2_dat_oe};
        end
        if (done === 1'b1 && err === 1'b1) both_cnt <= both_cnt + 1;
        prev_done <= done;
        if (prev_done === 1'b1) ready_after_done <= tx_ready;
        prev_ready <= tx_ready;
        if (prev_ready === 1'b1 && tx_ready === 1'b0) begin
            accept_cnt <= accept_cnt + 1;
            accept_cyc <= cyc;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tx_valid = 1'b0;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic start_tx(input logic [7:0] data, input bit hold);
        @(negedge clk);
        tx_data = data;
        tx_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (ps2_clk_oe !== 1'b1 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL accept_%h: clk_oe=%b tx_ready=%b expected clk_oe=1 tx_ready=0", data, ps2_clk_oe, tx_ready);
        end
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic dev_wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (ps2_clk_in === 1'b1 && ps2_dat_in === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic dev_clock(output logic sampled);
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        sampled = ps2_dat_in;
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic device_frame(output logic [9:0] bits, input bit ack);
        logic b;
        for (int k = 0; k < 10; k++) begin
            dev_clock(b);
            bits[k] = b;
        end
        dev_dat_low = ack;
        dev_clock(b);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_count_above(input bit which_err, input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ((which_err ? err_cnt : done_cnt) > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
            failures++;
            $display("FAIL reset_lines: ready=%b clk_oe=%b dat_oe=%b expected 1 0 0", tx_ready, ps2_clk_oe, ps2_dat_oe);
        end
        checks++;
        if (done !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
            failures++;
            $display("FAIL reset_status: done=%b err=%b code=%b expected 0 0 00", done, err, err_code);
        end
        do_reset();
    endtask

    task automatic test_send_f4();
        logic [9:0] bits;
        bit ok;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hF4, 1'b0);
        dev_wait_req(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL f4_req: no request-to-send seen"); end
        device_frame(bits, 1'b1);
        wait_count_above(1'b0, d0, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (last_run != INHIBIT_CYC) begin
            failures++;
            $display("FAIL f4_inhibit_len: got %0d expected %0d", last_run, INHIBIT_CYC);
        end
        checks++;
        if (bits !== 10'h2F4) begin failures++; $display("FAIL f4_frame: got %h expected 2f4", bits); end
        checks++;
        if (!ok || done_cnt != d0 + 1 || err_cnt != e0) begin
            failures++;
            $display("FAIL f4_done: done=%0d err=%0d expected done=%0d err=%0d", done_cnt - d0, err_cnt - e0, 1, 0);
        end
    endtask

    task automatic test_send_ed();
        logic [9:0] bits;
        bit ok;
        int d0;
        d0 = done_cnt;
        start_tx(8'hED, 1'b0);
        dev_wait_req(ok);
        device_frame(bits, 1'b1);
        wait_count_above(1'b0, d0, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (bits[8] !== 1'b1) begin failures++; $display("FAIL ed_parity: got %b expected 1", bits[8]); end
        checks++;
        if (bits !== 10'h3ED) begin failures++; $display("FAIL ed_frame: got %h expected 3ed", bits); end
        checks++;
        if (!ok || done_cnt != d0 + 1) begin failures++; $display("FAIL ed_done: got %0d pulses expected 1", done_cnt - d0); end
        checks++;
        if (ready_after_done !== 1'b1) begin failures++; $display("FAIL ed_ready_after_done: got %b expected 1", ready_after_done); end
    endtask

    task automatic test_nack();
        logic [9:0] bits;
        bit ok;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'h55, 1'b0);
        dev_wait_req(ok);
        device_frame(bits, 1'b0);
        wait_count_above(1'b1, e0, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (bits !== 10'h355) begin failures++; $display("FAIL nack_frame: got %h expected 355", bits); end
        checks++;
        if (!ok || err_cnt != e0 + 1 || err_code_seen !== 2'b10) begin
            failures++;
            $display("FAIL nack_err: pulses=%0d code=%b expected 1 10", err_cnt - e0, err_code_seen);
        end
        checks++;
        if (err_oe_seen !== 2'b00 || done_cnt != d0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL nack_release: oe=%b done=%0d ready=%b expected 00 0 1", err_oe_seen, done_cnt - d0, tx_ready);
        end
        checks++;
        if (err_code !== 2'b10) begin failures++; $display("FAIL nack_code_hold: got %b expected 10", err_code); end
    endtask

    task automatic test_timeout();
        bit ok;
        int e0;
        start_tx(8'hF4, 1'b0);
        dev_wait_req(ok);
        e0 = err_cnt;
        repeat (TIMEOUT_CYC + 100) @(negedge clk);
`ifdef PS2_TX_TIMEOUT_EN
        checks++;
        if (err_cnt != e0 + 1 || err_code_seen !== 2'b01) begin
            failures++;
            $display("FAIL timeout_err: pulses=%0d code=%b expected 1 01", err_cnt - e0, err_code_seen);
        end
        checks++;
        if (err_cyc - release_cyc != TIMEOUT_CYC) begin
            failures++;
            $display("FAIL timeout_latency: got %0d expected %0d", err_cyc - release_cyc, TIMEOUT_CYC);
        end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_release: clk_oe=%b dat_oe=%b ready=%b expected 0 0 1", ps2_clk_oe, ps2_dat_oe, tx_ready);
        end
`else
        checks++;
        if (err_cnt != e0) begin failures++; $display("FAIL no_timeout_err: got %0d pulses expected 0", err_cnt - e0); end
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL no_timeout_req: clk_oe=%b dat_oe=%b ready=%b expected 0 1 0", ps2_clk_oe, ps2_dat_oe, tx_ready);
        end
        do_reset();
`endif
    endtask

    task automatic test_rst_mid();
        logic [9:0] bits;
        logic b;
        bit ok;
        int d0, e0;
        start_tx(8'hE7, 1'b0);
        dev_wait_req(ok);
        for (int k = 0; k < 4; k++) dev_clock(b);
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (ps2_dat_oe !== 1'b1) begin failures++; $display("FAIL rst_mid_bit4: dat_oe=%b expected 1", ps2_dat_oe); end
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || tx_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_lines: clk_oe=%b dat_oe=%b ready=%b expected 0 0 1", ps2_clk_oe, ps2_dat_oe, tx_ready);
        end
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (done_cnt != d0 || err_cnt != e0) begin
            failures++;
            $display("FAIL rst_mid_pulses: done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
        end
        d0 = done_cnt;
        start_tx(8'hFF, 1'b0);
        dev_wait_req(ok);
        device_frame(bits, 1'b1);
        wait_count_above(1'b0, d0, ok);
        checks++;
        if (bits !== 10'h3FF || !ok) begin failures++; $display("FAIL ff_after_rst: frame=%h done=%b expected 3ff 1", bits, ok); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        bit ok, ok2;
        int d0, a0;
        d0 = done_cnt;
        a0 = accept_cnt;
        start_tx(8'hF4, 1'b1);
        tx_data = 8'hED;
        dev_wait_req(ok);
        device_frame(bits, 1'b1);
        ok2 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (accept_cnt > a0 + 1) begin ok2 = 1'b1; break; end
        end
        tx_valid = 1'b0;
        checks++;
        if (bits !== 10'h2F4) begin failures++; $display("FAIL b2b_first_frame: got %h expected 2f4", bits); end
        checks++;
        if (!ok2 || done_cnt != d0 + 1 || accept_cyc != done_cyc + 1) begin
            failures++;
            $display("FAIL b2b_second_accept: accepted=%b done=%0d gap=%0d expected 1 1 1", ok2, done_cnt - d0, accept_cyc - done_cyc);
        end
        dev_wait_req(ok);
        device_frame(bits, 1'b1);
        wait_count_above(1'b0, d0 + 1, ok);
        checks++;
        if (bits !== 10'h3ED || !ok) begin failures++; $display("FAIL b2b_second_frame: frame=%h done=%b expected 3ed 1", bits, ok); end
    endtask

    initial begin
        test_reset();
        test_send_f4();
        test_send_ed();
        test_nack();
        test_timeout();
        test_rst_mid();
        test_back_to_back();
        repeat (5) @(negedge clk);
        checks++;
        if (both_cnt != 0) begin failures++; $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
